// File: rtl/safecrack_lock_gen.sv
`default_nettype none
// ============================================================================
//  Module      : safecrack_lock_gen
//  Description : Parametrised combination lock. Active-low keys are
//                synchronised and edge-detected, then drive an entry / open /
//                error / lockout / programming state machine. The code lives
//                in a run-time programmable register. LEDs report progress.
//  Revision    : 1.0 - initial release
// ============================================================================
module safecrack_lock_gen #(
    parameter int NUM_BTNS       = 4,
    parameter int CODE_LEN       = 4,
    parameter logic [CODE_LEN*$clog2(NUM_BTNS)-1:0] DEFAULT_CODE = 8'hE4,
    parameter bit EARLY_ERR      = 1'b1,
    parameter int OPEN_CYCLES    = 250_000_000,
    parameter int ERR_CYCLES     = 150_000_000,
    parameter int MAX_FAILS      = 3,
    parameter int LOCKOUT_CYCLES = 500_000_000
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_BTNS-1:0]              btn,
    input  logic                             prog_req,
    output logic [CODE_LEN-1:0]              led_green,
    output logic                             led_red,
    output logic                             open,
    output logic                             lockout,
    output logic                             prog_active,
    output logic [$clog2(MAX_FAILS+1)-1:0]   fail_count
);

    localparam int c_idx_w  = $clog2(NUM_BTNS);
    localparam int c_code_w = CODE_LEN * c_idx_w;
    localparam int c_pos_w  = (CODE_LEN > 1) ? $clog2(CODE_LEN) : 1;
    localparam int c_fail_w = $clog2(MAX_FAILS + 1);
    localparam int c_max_cyc =
        (OPEN_CYCLES > ERR_CYCLES)
            ? ((OPEN_CYCLES > LOCKOUT_CYCLES) ? OPEN_CYCLES : LOCKOUT_CYCLES)
            : ((ERR_CYCLES  > LOCKOUT_CYCLES) ? ERR_CYCLES  : LOCKOUT_CYCLES);
    localparam int c_tmr_w  = $clog2(c_max_cyc + 1);

    localparam logic [c_pos_w-1:0]  c_last_pos  = c_pos_w'(CODE_LEN - 1);
    localparam logic [c_pos_w-1:0]  c_pos_one   = c_pos_w'(1);
    localparam logic [c_fail_w-1:0] c_fail_one  = c_fail_w'(1);
    localparam logic [c_fail_w-1:0] c_fail_max  = c_fail_w'(MAX_FAILS);
    localparam logic [c_tmr_w-1:0]  c_tmr_one   = c_tmr_w'(1);
    localparam logic [c_tmr_w-1:0]  c_open_last = c_tmr_w'(OPEN_CYCLES - 1);
    localparam logic [c_tmr_w-1:0]  c_err_last  = c_tmr_w'(ERR_CYCLES - 1);
    localparam logic [c_tmr_w-1:0]  c_lock_last = c_tmr_w'(LOCKOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_ENTRY   = 3'd0,
        ST_OPEN    = 3'd1,
        ST_ERROR   = 3'd2,
        ST_LOCKOUT = 3'd3,
        ST_PROG    = 3'd4
    } state_e;

    // Synchroniser flops carry no reset so they keep tracking the keys while
    // rst is high; a key held through reset is then already "pressed" when
    // prev is released from all-ones, and produces no edge.
    logic [NUM_BTNS-1:0] sync1_q, sync2_q;
    logic [NUM_BTNS-1:0] prev_q, prev_d;
    state_e              state_q, state_d;
    logic [c_pos_w-1:0]  pos_q, pos_d;
    logic                miss_q, miss_d;
    logic [c_fail_w-1:0] fail_q, fail_d;
    logic [c_code_w-1:0] code_q, code_d;
    logic [c_code_w-1:0] shadow_q, shadow_d;
    logic [c_tmr_w-1:0]  timer_q, timer_d;

    logic [NUM_BTNS-1:0] pressed;
    logic [NUM_BTNS-1:0] key_edge;
    logic                any_edge;
    logic                single_edge;
    logic [c_idx_w-1:0]  key_digit;
    logic [c_idx_w-1:0]  code_digit;
    logic                digit_ok;
    logic [c_code_w-1:0] shadow_wr;
    logic [c_fail_w-1:0] fail_inc;
    logic                fail_evt;
    logic                tmr_restart;
    logic [CODE_LEN-1:0] therm;

    // Two-stage synchroniser for the asynchronous keys
    always_ff @(posedge clk) begin
        sync1_q <= btn;
        sync2_q <= sync1_q;
    end

    assign pressed  = ~sync2_q;
    assign key_edge = pressed & ~prev_q;
    assign any_edge = |key_edge;
    // One-hot test: clearing the lowest set bit must leave nothing behind
    assign single_edge = any_edge &&
        ((key_edge & (key_edge - NUM_BTNS'(1))) == '0);
    assign fail_inc = fail_q + c_fail_one;

    // Key index encoder and code/shadow digit selection at the current position
    always_comb begin
        key_digit  = '0;
        code_digit = '0;
        shadow_wr  = shadow_q;
        for (int i = 0; i < NUM_BTNS; i++) begin
            if (key_edge[i]) key_digit = c_idx_w'(i);
        end
        for (int i = 0; i < CODE_LEN; i++) begin
            if (pos_q == c_pos_w'(i)) begin
                code_digit                   = code_q[i*c_idx_w +: c_idx_w];
                shadow_wr[i*c_idx_w +: c_idx_w] = key_digit;
            end
        end
    end

    // A multi-press can never match; code digits beyond the key range never
    // equal an encoded key index, so they never match either.
    assign digit_ok = single_edge && (code_digit == key_digit);

    // Next-state logic: entry checking, timed states, programming
    always_comb begin
        state_d     = state_q;
        pos_d       = pos_q;
        miss_d      = miss_q;
        fail_d      = fail_q;
        code_d      = code_q;
        shadow_d    = shadow_q;
        timer_d     = timer_q;
        prev_d      = pressed;
        fail_evt    = 1'b0;
        tmr_restart = 1'b0;

        case (state_q)
            ST_ENTRY: begin
                if (any_edge) begin
                    if (EARLY_ERR) begin
                        if (!digit_ok) begin
                            fail_evt = 1'b1;
                        end else if (pos_q == c_last_pos) begin
                            state_d = ST_OPEN;
                        end else begin
                            pos_d = pos_q + c_pos_one;
                        end
                    end else begin
                        if (pos_q == c_last_pos) begin
                            if (!miss_q && digit_ok) state_d  = ST_OPEN;
                            else                     fail_evt = 1'b1;
                        end else begin
                            pos_d  = pos_q + c_pos_one;
                            miss_d = miss_q | ~digit_ok;
                        end
                    end
                end
                if (state_d == ST_OPEN) begin
                    pos_d  = '0;
                    miss_d = 1'b0;
                    fail_d = '0;
                end
            end
            ST_OPEN: begin
                if (prog_req) begin
                    state_d  = ST_PROG;
                    pos_d    = '0;
                    shadow_d = code_q;
                end else if (timer_q == c_open_last) begin
                    state_d = ST_ENTRY;
                end
            end
            ST_ERROR: begin
                if (timer_q == c_err_last) state_d = ST_ENTRY;
            end
            ST_LOCKOUT: begin
                if (timer_q == c_lock_last) begin
                    state_d = ST_ENTRY;
                    fail_d  = '0;
                end
            end
            ST_PROG: begin
                // Completing the code takes priority over an abort in the same cycle
                if (single_edge && (pos_q == c_last_pos)) begin
                    code_d  = shadow_wr;
                    state_d = ST_ENTRY;
                    pos_d   = '0;
                end else if (!prog_req) begin
                    state_d = ST_ENTRY;
                    pos_d   = '0;
                end else if (single_edge) begin
                    shadow_d    = shadow_wr;
                    pos_d       = pos_q + c_pos_one;
                    tmr_restart = 1'b1;
                end else if (timer_q == c_open_last) begin
                    state_d = ST_ENTRY;
                    pos_d   = '0;
                end
            end
            default: begin
                state_d = ST_ENTRY;
                pos_d   = '0;
                miss_d  = 1'b0;
            end
        endcase

        if (fail_evt) begin
            fail_d  = fail_inc;
            state_d = (fail_inc == c_fail_max) ? ST_LOCKOUT : ST_ERROR;
            pos_d   = '0;
            miss_d  = 1'b0;
        end

        // Timed states leave on their last count, so the timer never wraps
        if ((state_d != state_q) || tmr_restart) begin
            timer_d = '0;
        end else if (state_q != ST_ENTRY) begin
            timer_d = timer_q + c_tmr_one;
        end
    end

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_ENTRY;
            pos_q    <= '0;
            miss_q   <= 1'b0;
            fail_q   <= '0;
            code_q   <= DEFAULT_CODE;
            shadow_q <= DEFAULT_CODE;
            timer_q  <= '0;
            prev_q   <= '1;
        end else begin
            state_q  <= state_d;
            pos_q    <= pos_d;
            miss_q   <= miss_d;
            fail_q   <= fail_d;
            code_q   <= code_d;
            shadow_q <= shadow_d;
            timer_q  <= timer_d;
            prev_q   <= prev_d;
        end
    end

    generate
        for (genvar g = 0; g < CODE_LEN; g++) begin : g_therm
            assign therm[g] = (pos_q > c_pos_w'(g));
        end
    endgenerate

    // Moore output decode from registered state and position
    always_comb begin
        led_green   = '0;
        led_red     = 1'b0;
        open        = 1'b0;
        lockout     = 1'b0;
        prog_active = 1'b0;
        case (state_q)
            ST_ENTRY:   led_green = therm;
            ST_OPEN: begin
                led_green = '1;
                open      = 1'b1;
            end
            ST_ERROR:   led_red = 1'b1;
            ST_LOCKOUT: begin
                led_red = 1'b1;
                lockout = 1'b1;
            end
            ST_PROG: begin
                led_green   = therm;
                prog_active = 1'b1;
            end
            default:    led_green = '0;
        endcase
    end

    assign fail_count = fail_q;

endmodule
`default_nettype wire

// File: tb/tb_safecrack_lock_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_safecrack_lock_gen
//  Description : Bench for safecrack_lock_gen. Two lock instances (early and
//                late error reporting) share the same key stimulus; a
//                behavioural lock model predicts both every cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_safecrack_lock_gen;

    localparam int NB     = 4;
    localparam int CL     = 4;
    localparam int T_OPEN = 20;
    localparam int T_ERR  = 10;
    localparam int T_LOCK = 40;
    localparam int MAXF   = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] btn = 4'hF;
    logic       prog_req = 1'b0;

    logic [3:0] lg_e, lg_l;
    logic       red_e, red_l, open_e, open_l, lock_e, lock_l, prog_e, prog_l;
    logic [1:0] fc_e, fc_l;

    always #5 clk = ~clk;

    safecrack_lock_gen #(
        .NUM_BTNS(NB), .CODE_LEN(CL), .DEFAULT_CODE(8'hE4), .EARLY_ERR(1'b1),
        .OPEN_CYCLES(T_OPEN), .ERR_CYCLES(T_ERR), .MAX_FAILS(MAXF),
        .LOCKOUT_CYCLES(T_LOCK)
    ) dut_early (
        .clk(clk), .rst(rst), .btn(btn), .prog_req(prog_req),
        .led_green(lg_e), .led_red(red_e), .open(open_e), .lockout(lock_e),
        .prog_active(prog_e), .fail_count(fc_e)
    );

    safecrack_lock_gen #(
        .NUM_BTNS(NB), .CODE_LEN(CL), .DEFAULT_CODE(8'hE4), .EARLY_ERR(1'b0),
        .OPEN_CYCLES(T_OPEN), .ERR_CYCLES(T_ERR), .MAX_FAILS(MAXF),
        .LOCKOUT_CYCLES(T_LOCK)
    ) dut_late (
        .clk(clk), .rst(rst), .btn(btn), .prog_req(prog_req),
        .led_green(lg_l), .led_red(red_l), .open(open_l), .lockout(lock_l),
        .prog_active(prog_l), .fail_count(fc_l)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got 0x%h expected 0x%h", tag, $time, obs, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model: one entry per lock (0 = early, 1 = late errors)
    // ------------------------------------------------------------------
    typedef enum {M_ENTRY, M_OPEN, M_ERROR, M_LOCK, M_PROG} mode_t;
    mode_t md[2];
    int    left[2];
    int    fails[2];
    int    cnt[2];
    bit    miss[2];
    int    code[2][4];
    int    sh[2][4];

    // key history as sampled on each rising edge, plus reset one edge back
    logic [3:0] h1 = 4'hF, h2 = 4'hF, h3 = 4'hF;
    bit         rh1 = 1'b1;
    bit         started = 1'b0;

    task automatic model_reset(input int m);
        md[m] = M_ENTRY; left[m] = 0; fails[m] = 0; cnt[m] = 0; miss[m] = 0;
        for (int j = 0; j < 4; j++) begin
            code[m][j] = j;
            sh[m][j]   = j;
        end
    endtask

    task automatic model_fail(input int m);
        fails[m]++;
        cnt[m]  = 0;
        miss[m] = 0;
        if (fails[m] == MAXF) begin md[m] = M_LOCK;  left[m] = T_LOCK; end
        else                  begin md[m] = M_ERROR; left[m] = T_ERR;  end
    endtask

    task automatic model_step(input int m, input bit early, input logic [3:0] ev);
        bit single;
        int dig;
        bit ok;
        single = ($countones(ev) == 1);
        dig = 0;
        for (int k = 0; k < NB; k++) if (ev[k]) dig = k;
        case (md[m])
            M_ENTRY: if (ev != 0) begin
                ok = single && (dig == code[m][cnt[m]]);
                if (early && !ok) model_fail(m);
                else begin
                    miss[m] = miss[m] | !ok;
                    cnt[m]++;
                    if (cnt[m] == CL) begin
                        if (miss[m]) model_fail(m);
                        else begin
                            md[m] = M_OPEN; left[m] = T_OPEN; fails[m] = 0; cnt[m] = 0;
                        end
                    end
                end
            end
            M_OPEN: begin
                if (prog_req) begin
                    md[m] = M_PROG; cnt[m] = 0; left[m] = T_OPEN; sh[m] = code[m];
                end else begin
                    left[m]--;
                    if (left[m] == 0) md[m] = M_ENTRY;
                end
            end
            M_ERROR: begin
                left[m]--;
                if (left[m] == 0) md[m] = M_ENTRY;
            end
            M_LOCK: begin
                left[m]--;
                if (left[m] == 0) begin md[m] = M_ENTRY; fails[m] = 0; end
            end
            M_PROG: begin
                if (single && cnt[m] == CL - 1) begin
                    sh[m][cnt[m]] = dig; code[m] = sh[m]; md[m] = M_ENTRY; cnt[m] = 0;
                end else if (!prog_req) begin
                    md[m] = M_ENTRY; cnt[m] = 0;
                end else if (single) begin
                    sh[m][cnt[m]] = dig; cnt[m]++; left[m] = T_OPEN;
                end else begin
                    left[m]--;
                    if (left[m] == 0) begin md[m] = M_ENTRY; cnt[m] = 0; end
                end
            end
            default: md[m] = M_ENTRY;
        endcase
    endtask

    function automatic logic [9:0] exp_out(input int m);
        logic [3:0] lg;
        logic red, op, lk, pa;
        lg = 4'h0; red = 0; op = 0; lk = 0; pa = 0;
        case (md[m])
            M_ENTRY: lg = 4'((1 << cnt[m]) - 1);
            M_PROG:  begin lg = 4'((1 << cnt[m]) - 1); pa = 1; end
            M_OPEN:  begin lg = 4'hF; op = 1; end
            M_ERROR: red = 1;
            M_LOCK:  begin red = 1; lk = 1; end
            default: lg = 4'h0;
        endcase
        return {lg, red, op, lk, pa, 2'(fails[m])};
    endfunction

    // Model advance on every rising edge: a key registers two edges after the
    // sample where it is first seen down, if the sample before saw it up and
    // reset was not active on the previous edge.
    initial begin
        logic [3:0] ev;
        model_reset(0);
        model_reset(1);
        forever begin
            @(posedge clk);
            ev = ~h2 & h3 & {4{~rh1}};
            if (rst) begin
                model_reset(0);
                model_reset(1);
            end else begin
                model_step(0, 1'b1, ev);
                model_step(1, 1'b0, ev);
            end
            h3 = h2; h2 = h1; h1 = btn; rh1 = rst;
            started = 1'b1;
        end
    end

    // Compare both locks against the model on every falling edge
    initial begin
        forever begin
            @(negedge clk);
            if (started) begin
                check_eq("early_outputs", {6'd0, lg_e, red_e, open_e, lock_e, prog_e, fc_e}, {6'd0, exp_out(0)});
                check_eq("late_outputs",  {6'd0, lg_l, red_l, open_l, lock_l, prog_l, fc_l}, {6'd0, exp_out(1)});
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers (all start and end on a falling edge)
    // ------------------------------------------------------------------
    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic key(input logic [3:0] mask, input int hold, input int gap);
        btn = ~mask;
        repeat (hold) @(negedge clk);
        btn = 4'hF;
        repeat (gap) @(negedge clk);
    endtask

    task automatic enter(input int d0, input int d1, input int d2, input int d3);
        key(4'(1 << d0), 2, 2);
        key(4'(1 << d1), 2, 2);
        key(4'(1 << d2), 2, 2);
        key(4'(1 << d3), 2, 2);
    endtask

    initial begin
        int r;
        @(negedge clk);
        rst = 1'b1;
        idle(4);
        rst = 1'b0;
        idle(2);

        // correct default code, then let OPEN expire
        enter(0, 1, 2, 3);
        idle(25);

        // wrong second digit; extra keys while early lock is in ERROR
        key(4'b0001, 2, 2);
        key(4'b0100, 2, 2);
        key(4'b0010, 2, 2);
        key(4'b0010, 2, 2);
        idle(15);
        // late lock: 0,2,2,3 reaches 0111 before reporting
        enter(0, 2, 2, 3);
        idle(15);

        // correct code clears the failure count
        enter(0, 1, 2, 3);
        idle(25);

        // repeated failures into lockout
        for (int a = 0; a < 3; a++) begin
            enter(3, 3, 3, 3);
            idle(15);
        end
        idle(45);

        // simultaneous keys in ENTRY
        key(4'b0011, 2, 2);
        idle(15);

        // key held through reset release never registers
        btn = 4'hE;
        rst = 1'b1;
        idle(3);
        rst = 1'b0;
        idle(6);
        btn = 4'hF;
        idle(3);
        enter(0, 1, 2, 3);
        idle(3);

        // program 3,3,1,0 (multi-press in PROG ignored)
        prog_req = 1'b1;
        idle(2);
        key(4'b0011, 2, 2);
        enter(3, 3, 1, 0);
        prog_req = 1'b0;
        idle(5);
        enter(3, 3, 1, 0);
        idle(25);
        enter(0, 1, 2, 3);
        idle(15);

        // abort after two digits keeps the code
        enter(3, 3, 1, 0);
        idle(3);
        prog_req = 1'b1;
        key(4'b0100, 2, 2);
        key(4'b0100, 2, 2);
        prog_req = 1'b0;
        idle(5);
        enter(3, 3, 1, 0);
        idle(3);

        // idle timeout in PROG
        prog_req = 1'b1;
        idle(30);
        prog_req = 1'b0;
        idle(25);

        // reset restores the default code
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
        idle(2);
        enter(0, 1, 2, 3);
        idle(25);

        // randomized keys, programming requests and resets
        for (int i = 0; i < 250; i++) begin
            r = $urandom_range(0, 9);
            if (r < 2) begin
                for (int j = 0; j < 4; j++)
                    key(4'(1 << code[0][j]), 1 + $urandom_range(0, 1), 1 + $urandom_range(0, 2));
            end else if (r == 2) begin
                prog_req = ~prog_req;
                idle(1);
            end else if (r == 3) begin
                key(4'($urandom_range(1, 15)), 1, $urandom_range(1, 3));
            end else begin
                key(4'(1 << $urandom_range(0, 3)), $urandom_range(1, 3), $urandom_range(1, 3));
            end
            if ($urandom_range(0, 15) == 0) idle(30);
            if ($urandom_range(0, 63) == 0) begin
                rst = 1'b1;
                idle(2);
                rst = 1'b0;
            end
        end
        prog_req = 1'b0;
        idle(50);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
